// File: rtl/rename_regfile.sv
// Architectural register file plus per-register rename state (busy + producing ROB tag).
// Reads are combinational with commit bypass; rename/commit/flush update state on the rising edge.
module rename_regfile #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ROB_TAG_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic [DATA_W-1:0]     operand1,
  output logic [DATA_W-1:0]     operand2,
  output logic [ROB_TAG_W-1:0]  tag1,
  output logic [ROB_TAG_W-1:0]  tag2,
  output logic                  busy1,
  output logic                  busy2,
  input  logic                  rename_ena,
  input  logic [REG_ADDR_W-1:0] rename_rd,
  input  logic [ROB_TAG_W-1:0]  rename_tag,
  input  logic                  commit_ena,
  input  logic [REG_ADDR_W-1:0] commit_rd,
  input  logic [ROB_TAG_W-1:0]  commit_tag,
  input  logic [DATA_W-1:0]     commit_value,
  input  logic                  flush
);
  localparam int NREG = 1 << REG_ADDR_W;

  logic [DATA_W-1:0]    value_q [NREG];
  logic [DATA_W-1:0]    value_d [NREG];
  logic [ROB_TAG_W-1:0] tag_q   [NREG];
  logic [ROB_TAG_W-1:0] tag_d   [NREG];
  logic [NREG-1:0]      busy_q;
  logic [NREG-1:0]      busy_d;

  // Commit clears rename state only when no younger rename has replaced the tag;
  // a same-cycle rename is applied afterwards so it always wins.
  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    for (int i = 1; i < NREG; i++) begin
      if (commit_ena && commit_rd == REG_ADDR_W'(i)) begin
        value_d[i] = commit_value;
        if (tag_q[i] == commit_tag) begin
          busy_d[i] = 1'b0;
          tag_d[i]  = '0;
        end
      end
      if (flush) begin
        busy_d[i] = 1'b0;
        tag_d[i]  = '0;
      end else if (rename_ena && rename_rd == REG_ADDR_W'(i)) begin
        busy_d[i] = 1'b1;
        tag_d[i]  = rename_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      value_q <= value_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    operand1 = '0;
    tag1     = '0;
    busy1    = 1'b0;
    if (rs1 != '0) begin
      if (commit_ena && commit_rd == rs1 && busy_q[rs1] && tag_q[rs1] == commit_tag) begin
        operand1 = commit_value;
      end else begin
        operand1 = value_q[rs1];
        busy1    = busy_q[rs1];
        tag1     = busy_q[rs1] ? tag_q[rs1] : '0;
      end
    end
  end

  always_comb begin
    operand2 = '0;
    tag2     = '0;
    busy2    = 1'b0;
    if (rs2 != '0) begin
      if (commit_ena && commit_rd == rs2 && busy_q[rs2] && tag_q[rs2] == commit_tag) begin
        operand2 = commit_value;
      end else begin
        operand2 = value_q[rs2];
        busy2    = busy_q[rs2];
        tag2     = busy_q[rs2] ? tag_q[rs2] : '0;
      end
    end
  end
endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile: reset, rename/commit bypass, stale commits, flush, x0.
module tb_rename_regfile;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2;
  logic [31:0] operand1, operand2;
  logic [3:0]  tag1, tag2;
  logic        busy1, busy2;
  logic        rename_ena;
  logic [4:0]  rename_rd;
  logic [3:0]  rename_tag;
  logic        commit_ena;
  logic [4:0]  commit_rd;
  logic [3:0]  commit_tag;
  logic [31:0] commit_value;
  logic        flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rename_regfile dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
    .operand1(operand1), .operand2(operand2),
    .tag1(tag1), .tag2(tag2), .busy1(busy1), .busy2(busy2),
    .rename_ena(rename_ena), .rename_rd(rename_rd), .rename_tag(rename_tag),
    .commit_ena(commit_ena), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_value(commit_value), .flush(flush)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic chk1(input string name, input logic [31:0] op, input logic [31:0] op_e,
                      input logic bsy, input logic bsy_e, input logic [3:0] tg, input logic [3:0] tg_e);
    chk({name, ".operand"}, op, op_e);
    chk({name, ".busy"}, 32'(bsy), 32'(bsy_e));
    chk({name, ".tag"}, 32'(tg), 32'(tg_e));
  endtask

  // Apply the currently driven inputs on one rising edge, then return at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rename_ena = 1'b0; commit_ena = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rs1 = 5'd0; rs2 = 5'd0;
    rename_ena = 1'b0; rename_rd = 5'd0; rename_tag = 4'd0;
    commit_ena = 1'b0; commit_rd = 5'd0; commit_tag = 4'd0; commit_value = 32'd0;
    flush = 1'b0;
    step();
    rst = 1'b0;

    // Reset state
    rs1 = 5'd5; rs2 = 5'd0; #1;
    chk1("reset_rs1", operand1, 32'd0, busy1, 1'b0, tag1, 4'd0);
    chk1("reset_rs2", operand2, 32'd0, busy2, 1'b0, tag2, 4'd0);

    // Rename x3 tag 2, then commit with bypass
    rename_ena = 1'b1; rename_rd = 5'd3; rename_tag = 4'd2;
    step(); idle();
    rs1 = 5'd3; #1;
    chk1("x3_renamed", operand1, 32'd0, busy1, 1'b1, tag1, 4'd2);
    commit_ena = 1'b1; commit_rd = 5'd3; commit_tag = 4'd2; commit_value = 32'hDEAD; #1;
    chk1("x3_bypass", operand1, 32'hDEAD, busy1, 1'b0, tag1, 4'd0);
    step(); idle(); #1;
    chk1("x3_committed", operand1, 32'hDEAD, busy1, 1'b0, tag1, 4'd0);

    // Two renames of x4; stale commit must not clear busy
    rename_ena = 1'b1; rename_rd = 5'd4; rename_tag = 4'd1;
    step();
    rename_tag = 4'd3;
    step(); idle();
    rs1 = 5'd4;
    commit_ena = 1'b1; commit_rd = 5'd4; commit_tag = 4'd1; commit_value = 32'd7; #1;
    chk1("x4_stale_nobypass", operand1, 32'd0, busy1, 1'b1, tag1, 4'd3);
    step(); idle(); #1;
    chk1("x4_after_stale", operand1, 32'd7, busy1, 1'b1, tag1, 4'd3);
    commit_ena = 1'b1; commit_tag = 4'd3; commit_value = 32'd9; #1;
    chk1("x4_bypass9", operand1, 32'd9, busy1, 1'b0, tag1, 4'd0);
    step(); idle(); #1;
    chk1("x4_final", operand1, 32'd9, busy1, 1'b0, tag1, 4'd0);

    // Same-cycle rename and commit of x6
    rename_ena = 1'b1; rename_rd = 5'd6; rename_tag = 4'd4;
    step(); idle();
    rs2 = 5'd6;
    rename_ena = 1'b1; rename_rd = 5'd6; rename_tag = 4'd5;
    commit_ena = 1'b1; commit_rd = 5'd6; commit_tag = 4'd4; commit_value = 32'h11; #1;
    chk1("x6_samecycle_read", operand2, 32'h11, busy2, 1'b0, tag2, 4'd0);
    step(); idle(); #1;
    chk1("x6_rename_wins", operand2, 32'h11, busy2, 1'b1, tag2, 4'd5);

    // Rename x1..x7, then flush with commit of x2 and a rename that must be dropped
    for (int i = 1; i <= 7; i++) begin
      rename_ena = 1'b1; rename_rd = 5'(i); rename_tag = 4'(i);
      step();
    end
    idle();
    rs1 = 5'd5; #1;
    chk1("x5_prefl", operand1, 32'd0, busy1, 1'b1, tag1, 4'd5);
    flush = 1'b1;
    commit_ena = 1'b1; commit_rd = 5'd2; commit_tag = 4'd2; commit_value = 32'h22;
    rename_ena = 1'b1; rename_rd = 5'd1; rename_tag = 4'd9;
    step(); idle();
    rs1 = 5'd2; rs2 = 5'd1; #1;
    chk1("x2_flush", operand1, 32'h22, busy1, 1'b0, tag1, 4'd0);
    chk1("x1_flush", operand2, 32'd0, busy2, 1'b0, tag2, 4'd0);
    rs1 = 5'd7; rs2 = 5'd4; #1;
    chk1("x7_flush", operand1, 32'd0, busy1, 1'b0, tag1, 4'd0);
    chk1("x4_flush", operand2, 32'd9, busy2, 1'b0, tag2, 4'd0);

    // Writes to x0 are ignored, including the read bypass
    rs1 = 5'd0;
    rename_ena = 1'b1; rename_rd = 5'd0; rename_tag = 4'd1;
    commit_ena = 1'b1; commit_rd = 5'd0; commit_tag = 4'd0; commit_value = 32'hFF; #1;
    chk1("x0_bypass", operand1, 32'd0, busy1, 1'b0, tag1, 4'd0);
    step(); idle(); #1;
    chk1("x0_after", operand1, 32'd0, busy1, 1'b0, tag1, 4'd0);

    // Reset mid-sequence clears everything and overrides a same-cycle rename
    rename_ena = 1'b1; rename_rd = 5'd5; rename_tag = 4'd6;
    step(); idle();
    rs1 = 5'd5; #1;
    chk1("x5_prerst", operand1, 32'd0, busy1, 1'b1, tag1, 4'd6);
    rst = 1'b1;
    rename_ena = 1'b1; rename_rd = 5'd3; rename_tag = 4'd7;
    commit_ena = 1'b1; commit_rd = 5'd4; commit_tag = 4'd3; commit_value = 32'h55;
    step(); idle(); rst = 1'b0;
    rs1 = 5'd3; rs2 = 5'd5; #1;
    chk1("x3_rst", operand1, 32'd0, busy1, 1'b0, tag1, 4'd0);
    chk1("x5_rst", operand2, 32'd0, busy2, 1'b0, tag2, 4'd0);
    rs1 = 5'd4; rs2 = 5'd6; #1;
    chk1("x4_rst", operand1, 32'd0, busy1, 1'b0, tag1, 4'd0);
    chk1("x6_rst", operand2, 32'd0, busy2, 1'b0, tag2, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
